// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between a CPU port
// and a word-wide Memory block, with saturating hit/miss counters.
module cache_ctrl #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpuaddr,
    input  logic        cpureq,
    input  logic        cpurw,
    input  logic [31:0] datafcpu,
    output logic [31:0] datatcpu,
    output logic        cpurdy,
    output logic [15:0] memaddr,
    output logic        req,
    output logic        rw,
    output logic [31:0] datatmem,
    input  logic [31:0] datafmem,
    input  logic        memrdy,
    output logic [15:0] hitcnt,
    output logic [15:0] misscnt
);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 14 - IDX;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid, dirty;
    logic [TAG-1:0]   tags  [LINES];
    logic [31:0]      lines [LINES];

    logic [13:0]    addr_q;
    logic           rw_q;
    logic [31:0]    wdata_q;
    logic           refill;
    logic [TAG-1:0] tag_q;
    logic [IDX-1:0] idx_q;
    logic           hit;
    logic           unused_bits;

    assign unused_bits = ^cpuaddr[1:0];
    assign tag_q = addr_q[13:IDX];
    assign idx_q = addr_q[IDX-1:0];
    assign hit   = valid[idx_q] && (tags[idx_q] == tag_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cpureq && !cpurdy) state_nx = COMPARE;
            COMPARE: begin
                if (hit)                               state_nx = IDLE;
                else if (valid[idx_q] && dirty[idx_q]) state_nx = WB_REQ;
                else                                   state_nx = FILL_REQ;
            end
            WB_REQ:    state_nx = WB_WAIT;
            WB_WAIT:   if (memrdy) state_nx = FILL_REQ;
            FILL_REQ:  state_nx = FILL_WAIT;
            FILL_WAIT: if (memrdy) state_nx = COMPARE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpurdy   <= 1'b0;
            req      <= 1'b0;
            rw       <= 1'b0;
            memaddr  <= '0;
            datatmem <= '0;
            datatcpu <= '0;
            hitcnt   <= '0;
            misscnt  <= '0;
            valid    <= '0;
            dirty    <= '0;
            refill   <= 1'b0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            cpurdy <= 1'b0;
            req    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpureq && !cpurdy) begin
                        addr_q  <= cpuaddr[15:2];
                        rw_q    <= cpurw;
                        wdata_q <= datafcpu;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (rw_q) dirty[idx_q] <= 1'b1;
                        else      datatcpu     <= lines[idx_q];
                        cpurdy <= 1'b1;
                        // The completion that follows a fill was already counted as a miss
                        if (!refill && hitcnt != '1) hitcnt <= hitcnt + 16'd1;
                        refill <= 1'b0;
                    end else if (misscnt != '1) begin
                        misscnt <= misscnt + 16'd1;
                    end
                end
                WB_REQ: begin
                    memaddr  <= {tags[idx_q], idx_q, 2'b00};
                    rw       <= 1'b1;
                    datatmem <= lines[idx_q];
                    req      <= 1'b1;
                end
                FILL_REQ: begin
                    memaddr <= {tag_q, idx_q, 2'b00};
                    rw      <= 1'b0;
                    req     <= 1'b1;
                end
                FILL_WAIT: begin
                    if (memrdy) begin
                        valid[idx_q] <= 1'b1;
                        dirty[idx_q] <= 1'b0;
                        refill       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line payload carries no reset; valid bits guard it
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && rw_q) begin
            lines[idx_q] <= wdata_q;
        end else if (state == FILL_WAIT && memrdy) begin
            lines[idx_q] <= datafmem;
            tags[idx_q]  <= tag_q;
        end
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate cache controller sitting between the CPU port and the word-wide Memory block. Serves CPU word reads/writes from an internal line array. On a miss it evicts a dirty victim to Memory and fills the line over the Memory req/rw/rdy handshake. Exposes saturating hit/miss counters for performance checks.

## Interface
- LINES, 16, number of one-word lines; power of two, ≥2; IDX = log2(LINES), TAG = 14-IDX bits
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cpuaddr  in  16  CPU byte address; [1:0] ignored, [IDX+1:2] index, [15:IDX+2] tag
- cpureq  in  1  CPU request, held high until cpurdy seen
- cpurw  in  1  1 = write, 0 = read
- datafcpu  in  32  CPU write data
- datatcpu  out  32  read data, valid while cpurdy=1
- cpurdy  out  1  one-cycle completion pulse
- memaddr  out  16  Memory word address {tag,index,2'b00}
- req  out  1  Memory request, one-cycle pulse
- rw  out  1  Memory direction, 1 = write
- datatmem  out  32  write-back data to Memory (its datafcac)
- datafmem  in  32  fill data from Memory (its datatcac)
- memrdy  in  1  Memory completion (its rdy)
- hitcnt, misscnt  out  16  saturating hit/miss counters

## Operation
- Per line: valid, dirty, TAG-bit tag, 32-bit data. Reset clears all valid and dirty; data/tag contents don't-care.
- States: IDLE, COMPARE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
- IDLE: if cpureq=1 and cpurdy=0, latch cpuaddr, cpurw, datafcpu; -> COMPARE. Otherwise stay.
- COMPARE, hit (valid and tag match):
  - Read: datatcpu <= line data.
  - Write: line data <= latched datafcpu; dirty <= 1.
  - In both cases cpurdy <= 1, hitcnt += 1 (saturate at 16'hFFFF), -> IDLE.
- COMPARE, miss: misscnt += 1 (saturating). If valid and dirty -> WB_REQ, else -> FILL_REQ. A miss is counted once; the re-entry to COMPARE after a fill is not counted as a hit.
- WB_REQ:
  - Drive memaddr = {victim tag, index, 00}, rw = 1, datatmem = victim data.
  - Pulse req for exactly one cycle; -> WB_WAIT.
- WB_WAIT: hold memaddr/rw/datatmem stable; on memrdy=1 -> FILL_REQ.
- FILL_REQ: drive memaddr = {new tag, index, 00}, rw = 0; pulse req one cycle; -> FILL_WAIT.
- FILL_WAIT: hold memaddr/rw stable; on memrdy=1 line data <= datafmem, tag <= new tag, valid <= 1, dirty <= 0; -> COMPARE, which completes as a hit-path access.
- memrdy is ignored outside WB_WAIT/FILL_WAIT. A stray pulse has no effect.
- Only one outstanding Memory transaction exists at any time. req is never asserted while waiting.
- Reset mid-operation: controller returns to IDLE immediately and the access is dropped. Memory is reset by the same system reset, and a late memrdy is ignored per the rule above.

## Timing
- Reset values: state IDLE, cpurdy 0, req 0, rw 0, memaddr 0, datatmem 0, datatcpu 0, hitcnt 0, misscnt 0.
- Hit: request accepted at edge n; cpurdy high for the cycle after edge n+1. This is 2-cycle latency.
- cpurdy is high exactly one cycle. A request still high during that cycle is not re-accepted, so the CPU drops cpureq on seeing cpurdy.
- Let M = edges from the req-assert edge to the edge at which memrdy is sampled high.
- Clean miss: cpurdy follows edge n+1+M+2.
- Dirty miss: cpurdy follows edge n+1+2M+3.
- req is registered and is high for exactly the cycle after the WB_REQ/FILL_REQ edge.
- memaddr, rw and datatmem stay constant from the req-assert edge through the memrdy-sampling edge.
- Counters update at the COMPARE edge.

## Test plan
- Reset, then read 16'h0000 with bench memory returning 32'hEFEFEFEF, 5-cycle rdy latency:
  - one req with rw=0, memaddr=16'h0000;
  - cpurdy with datatcpu=32'hEFEFEFEF;
  - misscnt=1, hitcnt=0.
- Repeat read 16'h0002 -> no req; cpurdy 2 cycles after accept; datatcpu=32'hEFEFEFEF; hitcnt=1.
- Write 32'h12345678 to 16'h0000, then read 16'h0040 (same index, LINES=16):
  - first req has rw=1, memaddr=16'h0000, datatmem=32'h12345678;
  - then req has rw=0, memaddr=16'h0040;
  - misscnt=2.
- Read 16'h0044 after reset with bench returning 32'hABABABAB -> single fill, no write-back (line clean), datatcpu=32'hABABABAB.
- Assert rst during FILL_WAIT, then inject memrdy -> no line valid, cpurdy stays 0. The next read of the same address issues a fresh req.
- Hold cpureq high continuously on a hit address -> exactly one cpurdy per 3 cycles; hitcnt increments by 1 per completion, with no duplicate accepts.
